// File: rtl/mac_pipe_sat_if.sv
// rtl/mac_pipe_sat_if.sv - operand/result bundle for the pipelined saturating MAC
interface mac_pipe_sat_if #(
    parameter int IN_W  = 8,
    parameter int ACC_W = 16,
    parameter int CNT_W = 8
);
    logic signed [IN_W-1:0]  a;
    logic signed [IN_W-1:0]  b;
    logic                    valid_in;
    logic                    clear_in;
    logic signed [ACC_W-1:0] f;
    logic                    valid_out;
    logic                    ovf;
    logic [CNT_W-1:0]        count;

    modport master (
        output a, b, valid_in, clear_in,
        input  f, valid_out, ovf, count
    );

    modport slave (
        input  a, b, valid_in, clear_in,
        output f, valid_out, ovf, count
    );
endinterface

// File: rtl/mac_pipe_sat.sv
// rtl/mac_pipe_sat.sv - pipelined signed multiply-accumulate with restart, saturation, sticky overflow and sample count
module mac_pipe_sat #(
    parameter int IN_W       = 8,
    parameter int ACC_W      = 16,
    parameter int MUL_STAGES = 1,
    parameter int SAT        = 1,
    parameter int CNT_W      = 8
) (
    input  logic          clk,
    input  logic          reset,
    mac_pipe_sat_if.slave bus
);
    localparam int P_W = 2 * IN_W;
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic signed [IN_W-1:0]  a_r;
    logic signed [IN_W-1:0]  b_r;
    logic                    v0;
    logic                    c0;
    logic signed [P_W-1:0]   prod;
    logic signed [P_W-1:0]   p_r [MUL_STAGES];
    logic                    mv  [MUL_STAGES];
    logic                    mc  [MUL_STAGES];
    logic signed [ACC_W:0]   addend;
    logic                    va;
    logic                    ca;
    logic signed [ACC_W:0]   base;
    logic signed [ACC_W:0]   sum;
    logic                    step_ovf;
    logic signed [ACC_W-1:0] f_next;
    logic [CNT_W-1:0]        cnt_next;
    logic signed [ACC_W-1:0] f_r;
    logic                    ovf_r;
    logic                    vout_r;
    logic [CNT_W-1:0]        cnt_r;

    always_ff @(posedge clk) begin
        if (reset) begin
            a_r <= '0;
            b_r <= '0;
            v0  <= 1'b0;
            c0  <= 1'b0;
        end else begin
            v0 <= bus.valid_in;
            if (bus.valid_in) begin
                a_r <= bus.a;
                b_r <= bus.b;
                c0  <= bus.clear_in;
            end
        end
    end

    assign prod = P_W'(a_r) * P_W'(b_r);

    // Later multiplier stages only retime the product so synthesis can balance it.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MUL_STAGES; i++) begin
                p_r[i] <= '0;
                mv[i]  <= 1'b0;
                mc[i]  <= 1'b0;
            end
        end else begin
            mv[0] <= v0;
            if (v0) begin
                p_r[0] <= prod;
                mc[0]  <= c0;
            end
            for (int i = 1; i < MUL_STAGES; i++) begin
                mv[i] <= mv[i-1];
                if (mv[i-1]) begin
                    p_r[i] <= p_r[i-1];
                    mc[i]  <= mc[i-1];
                end
            end
        end
    end

    // Sign-extension register keeps the multiplier output off the adder path.
    always_ff @(posedge clk) begin
        if (reset) begin
            addend <= '0;
            va     <= 1'b0;
            ca     <= 1'b0;
        end else begin
            va <= mv[MUL_STAGES-1];
            if (mv[MUL_STAGES-1]) begin
                addend <= {{(ACC_W+1-P_W){p_r[MUL_STAGES-1][P_W-1]}}, p_r[MUL_STAGES-1]};
                ca     <= mc[MUL_STAGES-1];
            end
        end
    end

    always_comb begin
        base     = ca ? '0 : {f_r[ACC_W-1], f_r};
        sum      = base + addend;
        step_ovf = sum[ACC_W] ^ sum[ACC_W-1];
        f_next   = sum[ACC_W-1:0];
        if (step_ovf && (SAT != 0)) begin
            f_next = sum[ACC_W] ? ACC_MIN : ACC_MAX;
        end
        if (ca) begin
            cnt_next = CNT_W'(1);
        end else if (&cnt_r) begin
            cnt_next = cnt_r;
        end else begin
            cnt_next = cnt_r + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            f_r    <= '0;
            ovf_r  <= 1'b0;
            cnt_r  <= '0;
            vout_r <= 1'b0;
        end else begin
            vout_r <= va;
            if (va) begin
                f_r   <= f_next;
                ovf_r <= ca ? step_ovf : (ovf_r | step_ovf);
                cnt_r <= cnt_next;
            end
        end
    end

    assign bus.f         = f_r;
    assign bus.ovf       = ovf_r;
    assign bus.count     = cnt_r;
    assign bus.valid_out = vout_r;
endmodule

// File: tb/tb_mac_pipe_sat.sv
// tb/tb_mac_pipe_sat.sv - self-checking bench for mac_pipe_sat across four parameter sets
module tb_mac_pipe_sat;
    typedef struct {
        int     dut;
        longint f;
        bit     ovf;
        int     cnt;
        int     cyc;
    } rec_t;

    logic clk;
    logic reset;
    logic signed [11:0] a_drv;
    logic signed [11:0] b_drv;
    logic valid;
    logic clear;
    int   cyc;
    int   checks;
    int   failures;

    // dut0: defaults; dut1: wrapping; dut2/dut3: wide operands, 1 and 4 multiplier stages
    int inw  [4] = '{8, 8, 12, 12};
    int accw [4] = '{16, 16, 32, 32};
    int lat  [4] = '{3, 3, 3, 6};
    int sat  [4] = '{1, 0, 1, 1};

    longint m_f   [4];
    bit     m_ovf [4];
    int     m_cnt [4];
    rec_t   exp_q [$];
    rec_t   obs_q [$];

    longint mon_f [4];
    bit     mon_o [4];
    bit     mon_v [4];
    int     mon_c [4];

    mac_pipe_sat_if #(.IN_W(8),  .ACC_W(16), .CNT_W(8)) i0 ();
    mac_pipe_sat_if #(.IN_W(8),  .ACC_W(16), .CNT_W(8)) i1 ();
    mac_pipe_sat_if #(.IN_W(12), .ACC_W(32), .CNT_W(8)) i2 ();
    mac_pipe_sat_if #(.IN_W(12), .ACC_W(32), .CNT_W(8)) i3 ();

    assign i0.a = a_drv[7:0];  assign i0.b = b_drv[7:0];  assign i0.valid_in = valid;  assign i0.clear_in = clear;
    assign i1.a = a_drv[7:0];  assign i1.b = b_drv[7:0];  assign i1.valid_in = valid;  assign i1.clear_in = clear;
    assign i2.a = a_drv;       assign i2.b = b_drv;       assign i2.valid_in = valid;  assign i2.clear_in = clear;
    assign i3.a = a_drv;       assign i3.b = b_drv;       assign i3.valid_in = valid;  assign i3.clear_in = clear;

    mac_pipe_sat #(.IN_W(8),  .ACC_W(16), .MUL_STAGES(1), .SAT(1), .CNT_W(8)) dut0 (.clk(clk), .reset(reset), .bus(i0.slave));
    mac_pipe_sat #(.IN_W(8),  .ACC_W(16), .MUL_STAGES(1), .SAT(0), .CNT_W(8)) dut1 (.clk(clk), .reset(reset), .bus(i1.slave));
    mac_pipe_sat #(.IN_W(12), .ACC_W(32), .MUL_STAGES(1), .SAT(1), .CNT_W(8)) dut2 (.clk(clk), .reset(reset), .bus(i2.slave));
    mac_pipe_sat #(.IN_W(12), .ACC_W(32), .MUL_STAGES(4), .SAT(1), .CNT_W(8)) dut3 (.clk(clk), .reset(reset), .bus(i3.slave));

    assign mon_f[0] = longint'(i0.f);  assign mon_o[0] = i0.ovf;  assign mon_v[0] = i0.valid_out;  assign mon_c[0] = int'(i0.count);
    assign mon_f[1] = longint'(i1.f);  assign mon_o[1] = i1.ovf;  assign mon_v[1] = i1.valid_out;  assign mon_c[1] = int'(i1.count);
    assign mon_f[2] = longint'(i2.f);  assign mon_o[2] = i2.ovf;  assign mon_v[2] = i2.valid_out;  assign mon_c[2] = int'(i2.count);
    assign mon_f[3] = longint'(i3.f);  assign mon_o[3] = i3.ovf;  assign mon_v[3] = i3.valid_out;  assign mon_c[3] = int'(i3.count);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int d = 0; d < 4; d++) begin
            if (mon_v[d] === 1'b1) obs_q.push_back('{d, mon_f[d], mon_o[d], mon_c[d], cyc});
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    // Reference: exact integer accumulation, then clamp or wrap to the accumulator range.
    function automatic void model_step(input int d, input longint av, input longint bv, input bit clr, input int out_cyc);
        longint one = 1;
        longint x, y, sum, mx, mn, m, nf;
        bit o;
        if (inw[d] == 8) begin
            x = ((av & 255) ^ 128) - 128;
            y = ((bv & 255) ^ 128) - 128;
        end else begin
            x = ((av & 4095) ^ 2048) - 2048;
            y = ((bv & 4095) ^ 2048) - 2048;
        end
        mx  = (one << (accw[d] - 1)) - 1;
        mn  = -mx - 1;
        sum = (clr ? 0 : m_f[d]) + x * y;
        o   = (sum > mx) || (sum < mn);
        if (!o) nf = sum;
        else if (sat[d] != 0) nf = (sum > mx) ? mx : mn;
        else begin
            m  = one << accw[d];
            nf = ((sum - mn) % m + m) % m + mn;
        end
        m_f[d]   = nf;
        m_ovf[d] = clr ? o : (m_ovf[d] | o);
        m_cnt[d] = clr ? 1 : ((m_cnt[d] >= 255) ? 255 : m_cnt[d] + 1);
        exp_q.push_back('{d, m_f[d], m_ovf[d], m_cnt[d], out_cyc});
    endfunction

    function automatic void model_reset();
        for (int d = 0; d < 4; d++) begin
            m_f[d] = 0; m_ovf[d] = 0; m_cnt[d] = 0;
        end
    endfunction

    function automatic bit get_obs(input int d, input int k, output rec_t r);
        int n = 0;
        r = '{default: 0};
        foreach (obs_q[i]) if (obs_q[i].dut == d) begin
            if (n == k) begin r = obs_q[i]; return 1'b1; end
            n++;
        end
        return 1'b0;
    endfunction

    function automatic bit get_exp(input int d, input int k, output rec_t r);
        int n = 0;
        r = '{default: 0};
        foreach (exp_q[i]) if (exp_q[i].dut == d) begin
            if (n == k) begin r = exp_q[i]; return 1'b1; end
            n++;
        end
        return 1'b0;
    endfunction

    function automatic int n_obs(input int d);
        int n = 0;
        foreach (obs_q[i]) if (obs_q[i].dut == d) n++;
        return n;
    endfunction

    task automatic send(input longint av, input longint bv, input bit clr);
        a_drv = av[11:0];
        b_drv = bv[11:0];
        valid = 1'b1;
        clear = clr;
        for (int d = 0; d < 4; d++) model_step(d, av, bv, clr, cyc + 1 + lat[d]);
        @(negedge clk);
    endtask

    // clear is driven high while idle: it must be ignored without valid_in
    task automatic idle(input int n);
        valid = 1'b0;
        clear = 1'b1;
        repeat (n) @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic pulse_reset();
        valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_reset();
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (mon_f[d] !== 0 || mon_o[d] !== 1'b0 || mon_c[d] !== 0 || mon_v[d] !== 1'b0) begin
                failures++;
                $display("FAIL reset_state dut%0d: f=%0d ovf=%0d count=%0d valid_out=%0d, required all 0",
                         d, mon_f[d], mon_o[d], mon_c[d], mon_v[d]);
            end
        end
    endtask

    task automatic test_basic();
        longint ef [3] = '{12, 2, 51};
        int     ec [3] = '{1, 2, 3};
        int     t0;
        rec_t   r;
        obs_q.delete();
        t0 = cyc + 1;
        send(3, 4, 1);
        send(-2, 5, 0);
        send(7, 7, 0);
        idle(10);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (!get_obs(0, k, r)) begin
                failures++;
                $display("FAIL basic_pulse #%0d: got no valid_out, required one", k);
            end else begin
                checks++;
                if (r.f !== ef[k] || r.cnt !== ec[k] || r.ovf !== 1'b0) begin
                    failures++;
                    $display("FAIL basic_value #%0d: got f=%0d count=%0d ovf=%0d, required f=%0d count=%0d ovf=0",
                             k, r.f, r.cnt, r.ovf, ef[k], ec[k]);
                end
                checks++;
                if (r.cyc !== t0 + 3 + k) begin
                    failures++;
                    $display("FAIL basic_latency #%0d: got cycle %0d, required %0d", k, r.cyc, t0 + 3 + k);
                end
            end
        end
    endtask

    task automatic test_bubbles_restart();
        longint ef [3] = '{100, 101, 6};
        int     ec [3] = '{1, 2, 1};
        rec_t   r;
        obs_q.delete();
        send(10, 10, 1);
        idle(2);
        send(1, 1, 0);
        send(2, 3, 1);
        idle(10);
        checks++;
        if (n_obs(0) !== 3) begin
            failures++;
            $display("FAIL bubble_pulse_count: got %0d valid_out pulses, required 3", n_obs(0));
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (!get_obs(0, k, r) || r.f !== ef[k] || r.cnt !== ec[k]) begin
                failures++;
                $display("FAIL bubble_value #%0d: got f=%0d count=%0d, required f=%0d count=%0d", k, r.f, r.cnt, ef[k], ec[k]);
            end
        end
    endtask

    task automatic test_saturation();
        longint ef0 [8] = '{16129, 32258, 32767, 32767, -16256, -32512, -32768, 1};
        longint ef1 [8] = '{16129, 32258, -17149, -17149, -16256, -32512, 16768, 1};
        bit     eo  [8] = '{0, 0, 1, 1, 0, 0, 1, 0};
        int     ec  [8] = '{1, 2, 3, 4, 1, 2, 3, 1};
        rec_t   r;
        obs_q.delete();
        send(127, 127, 1);
        send(127, 127, 0);
        send(127, 127, 0);
        send(0, 0, 0);
        send(-128, 127, 1);
        send(-128, 127, 0);
        send(-128, 127, 0);
        send(1, 1, 1);
        idle(10);
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (!get_obs(0, k, r) || r.f !== ef0[k] || r.ovf !== eo[k] || r.cnt !== ec[k]) begin
                failures++;
                $display("FAIL sat_clamp #%0d: got f=%0d ovf=%0d count=%0d, required f=%0d ovf=%0d count=%0d",
                         k, r.f, r.ovf, r.cnt, ef0[k], eo[k], ec[k]);
            end
            checks++;
            if (!get_obs(1, k, r) || r.f !== ef1[k] || r.ovf !== eo[k] || r.cnt !== ec[k]) begin
                failures++;
                $display("FAIL sat_wrap #%0d: got f=%0d ovf=%0d count=%0d, required f=%0d ovf=%0d count=%0d",
                         k, r.f, r.ovf, r.cnt, ef1[k], eo[k], ec[k]);
            end
        end
    endtask

    task automatic test_reset_midflight();
        rec_t r;
        obs_q.delete();
        send(7, 7, 1);
        send(3, 3, 0);
        pulse_reset();
        test_reset();
        idle(10);
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (n_obs(d) !== 0) begin
                failures++;
                $display("FAIL midflight_discard dut%0d: got %0d valid_out pulses, required 0", d, n_obs(d));
            end
        end
        send(5, 5, 0);
        idle(10);
        checks++;
        if (!get_obs(0, 0, r) || r.f !== 25 || r.cnt !== 1 || r.ovf !== 1'b0) begin
            failures++;
            $display("FAIL midflight_first dut0: got f=%0d count=%0d ovf=%0d, required f=25 count=1 ovf=0", r.f, r.cnt, r.ovf);
        end
        checks++;
        if (!get_obs(3, 0, r) || r.f !== 25 || r.cnt !== 1) begin
            failures++;
            $display("FAIL midflight_first dut3: got f=%0d count=%0d, required f=25 count=1", r.f, r.cnt);
        end
    endtask

    task automatic test_count_saturate();
        int   idx [3] = '{253, 254, 299};
        int   ec  [3] = '{254, 255, 255};
        rec_t r;
        obs_q.delete();
        send(0, 0, 1);
        for (int i = 1; i < 300; i++) send(0, 0, 0);
        idle(10);
        checks++;
        if (n_obs(0) !== 300) begin
            failures++;
            $display("FAIL count_pulses: got %0d pulses, required 300", n_obs(0));
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (!get_obs(0, idx[k], r) || r.cnt !== ec[k] || r.f !== 0) begin
                failures++;
                $display("FAIL count_sat #%0d: got count=%0d f=%0d, required count=%0d f=0", idx[k], r.cnt, r.f, ec[k]);
            end
        end
    endtask

    task automatic test_sweep();
        rec_t   r, e;
        int     t0, n;
        longint av, bv;
        pulse_reset();
        t0 = cyc + 1;
        send(2047, -2048, 1);
        idle(10);
        for (int d = 2; d < 4; d++) begin
            checks++;
            if (!get_obs(d, 0, r) || r.f !== -4192256 || r.cyc !== t0 + lat[d]) begin
                failures++;
                $display("FAIL sweep_corner dut%0d: got f=%0d at cycle %0d, required f=-4192256 at cycle %0d",
                         d, r.f, r.cyc, t0 + lat[d]);
            end
        end
        exp_q.delete();
        obs_q.delete();
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 5) == 0) idle(1);
            else begin
                case ($urandom_range(0, 3))
                    0: av = 2047;
                    1: av = -2048;
                    default: av = longint'($urandom_range(0, 4095)) - 2048;
                endcase
                bv = ($urandom_range(0, 1) == 0) ? longint'($urandom_range(0, 4095)) - 2048 : av;
                send(av, bv, $urandom_range(0, 39) == 0);
            end
        end
        idle(10);
        for (int d = 0; d < 4; d++) begin
            n = 0;
            while (get_exp(d, n, e)) begin
                checks++;
                if (!get_obs(d, n, r) || r.f !== e.f || r.ovf !== e.ovf || r.cnt !== e.cnt || r.cyc !== e.cyc) begin
                    failures++;
                    $display("FAIL sweep_random dut%0d #%0d: got f=%0d ovf=%0d count=%0d cycle=%0d, required f=%0d ovf=%0d count=%0d cycle=%0d",
                             d, n, r.f, r.ovf, r.cnt, r.cyc, e.f, e.ovf, e.cnt, e.cyc);
                end
                n++;
            end
            checks++;
            if (n_obs(d) !== n) begin
                failures++;
                $display("FAIL sweep_pulse_count dut%0d: got %0d pulses, required %0d", d, n_obs(d), n);
            end
        end
    endtask

    initial begin
        cyc      = 0;
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        valid    = 1'b0;
        clear    = 1'b0;
        a_drv    = '0;
        b_drv    = '0;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        test_reset();
        test_basic();
        test_bubbles_restart();
        test_saturation();
        test_reset_midflight();
        test_count_saturate();
        test_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
